// File: rtl/key_seq_pkg.sv
// Shared types, command codes and bit helpers for the key sequencer.
package key_seq_pkg;

   typedef enum logic [1:0] {
      LOCKED = 2'd0,
      UNLOCK = 2'd1,
      RUN    = 2'd2
   } fsm_t;

   localparam logic [3:0] CMD_RELOCK = 4'hF;

   function automatic logic parity(input logic [31:0] v);
      return ^v;
   endfunction

   // Rotate the low w bits of v left by n; bits at and above w come back zero.
   function automatic logic [31:0] rotl(input logic [31:0] v, input int w, input int n);
      logic [63:0] t;
      logic [63:0] m;
      int          s;
      s = n % w;
      m = (64'd1 << w) - 64'd1;
      t = ((({32'd0, v} & m) << s) | (({32'd0, v} & m) >> (w - s))) & m;
      return t[31:0];
   endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Fibonacci LFSR register with synchronous clear, seed load and step (priority in that order).
module seq_lfsr #(
   parameter int                 STATE_W = 6,
   parameter logic [STATE_W-1:0] TAPS    = 6'b110000,
   parameter logic [STATE_W-1:0] SEED    = 6'b000001
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic               step,
   output logic [STATE_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (load) begin
         q <= SEED;
      end else if (step) begin
         q <= {q[STATE_W-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/key_seq_engine.sv
// Bus-snooping challenge/response sequencer: a read-address key unlocks an LFSR
// whose parity-derived bits are returned on each subsequent window read.
module key_seq_engine
   import key_seq_pkg::*;
#(
   parameter int                   ADDR_W   = 14,
   parameter logic [1:0]           WIN      = 2'b01,
   parameter int                   STATE_W  = 6,
   parameter int                   DATA_W   = 1,
   parameter logic [STATE_W-1:0]   TAPS     = 6'b110000,
   parameter logic [STATE_W-1:0]   SEED     = 6'b000001,
   parameter logic [STATE_W-1:0]   OUT_MASK = 6'b100001,
   parameter int                   KEY_LEN  = 4,
   parameter logic [4*KEY_LEN-1:0] KEY      = 16'h9A92
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bus_stb,
   input  logic               bus_sel_n,
   input  logic [ADDR_W-1:0]  bus_addr,
   input  logic               bus_rd,
   output logic [DATA_W-1:0]  dout,
   output logic               dout_oe,
   output logic               locked,
   output logic [STATE_W-1:0] lfsr_q
);

   localparam logic [2:0] LAST_IDX = 3'(KEY_LEN - 1);

   fsm_t              state, state_n;
   logic [2:0]        idx, idx_n;
   logic [3:0]        key_arr [8];
   logic [3:0]        cmd;
   logic              acc;
   logic              hit_cur, hit_first, at_last;
   logic              lfsr_clr, lfsr_load, lfsr_step, resp_en;
   logic [DATA_W-1:0] resp;
   logic [STATE_W-1:0] lfsr;

   // Unpack the key into a fixed 8-entry table so idx never selects outside KEY.
   for (genvar g = 0; g < 8; g++) begin : g_key
      if (g < KEY_LEN) begin : g_used
         assign key_arr[g] = KEY[g*4 +: 4];
      end else begin : g_pad
         assign key_arr[g] = 4'h0;
      end
   end

   assign cmd       = bus_addr[7:4];
   assign acc       = bus_stb & ~bus_sel_n & bus_rd & (bus_addr[ADDR_W-1 -: 2] == WIN);
   assign hit_cur   = (cmd == key_arr[idx]);
   assign hit_first = (cmd == key_arr[0]);
   assign at_last   = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOCKED;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      if (acc) begin
         unique case (state)
            LOCKED: begin
               if (hit_first) begin
                  if (KEY_LEN == 1) begin
                     state_n = RUN;
                  end else begin
                     state_n = UNLOCK;
                     idx_n   = 3'd1;
                  end
               end
            end
            UNLOCK: begin
               if (hit_cur) begin
                  if (at_last) begin
                     state_n = RUN;
                     idx_n   = '0;
                  end else begin
                     idx_n = idx + 3'd1;
                  end
               end else if (hit_first) begin
                  idx_n = 3'd1;
               end else begin
                  state_n = LOCKED;
                  idx_n   = '0;
               end
            end
            RUN: begin
               if (cmd == CMD_RELOCK) begin
                  state_n = LOCKED;
               end
            end
            default: begin
               state_n = LOCKED;
               idx_n   = '0;
            end
         endcase
      end
   end

   always_comb begin
      lfsr_clr  = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      resp_en   = 1'b0;
      if (acc) begin
         unique case (state)
            LOCKED:  lfsr_load = hit_first && (KEY_LEN == 1);
            UNLOCK:  lfsr_load = hit_cur && at_last;
            RUN: begin
               if (cmd == CMD_RELOCK) begin
                  lfsr_clr = 1'b1;
               end else begin
                  lfsr_step = 1'b1;
                  resp_en   = 1'b1;
               end
            end
            default: lfsr_clr = 1'b1;
         endcase
      end
   end

   seq_lfsr #(
      .STATE_W (STATE_W),
      .TAPS    (TAPS),
      .SEED    (SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .clr  (lfsr_clr),
      .load (lfsr_load),
      .step (lfsr_step),
      .q    (lfsr)
   );

   // Response is taken from the LFSR value before this access steps it.
   always_comb begin
      resp = '0;
      for (int i = 0; i < DATA_W; i++) begin
         resp[i] = parity(32'(lfsr) & rotl(32'(OUT_MASK), STATE_W, i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout    <= '0;
         dout_oe <= 1'b0;
      end else begin
         dout_oe <= acc;
         if (acc) begin
            dout <= resp_en ? resp : '0;
         end
      end
   end

   assign locked = (state != RUN);
   assign lfsr_q = lfsr;

endmodule

// File: tb/tb_key_seq_engine.sv
// Bench for key_seq_engine: directed vector table, hand-written reset sequence,
// and randomized traffic against a behavioural model.
module tb_key_seq_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_stb;
   logic        bus_sel_n;
   logic [13:0] bus_addr;
   logic        bus_rd;
   logic [0:0]  dout;
   logic        dout_oe;
   logic        locked;
   logic [5:0]  lfsr_q;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   key_seq_engine dut (
      .clk       (clk),
      .rst       (rst),
      .bus_stb   (bus_stb),
      .bus_sel_n (bus_sel_n),
      .bus_addr  (bus_addr),
      .bus_rd    (bus_rd),
      .dout      (dout),
      .dout_oe   (dout_oe),
      .locked    (locked),
      .lfsr_q    (lfsr_q)
   );

   typedef struct {
      logic       rst, stb, sel_n, rd;
      logic [1:0] win;
      logic [3:0] cmd;
      logic       oe, dout, locked;
      logic [5:0] lfsr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic s, logic sn, logic rd, logic [1:0] w, logic [3:0] c,
                               logic oe, logic d, logic lk, logic [5:0] lf);
      vec_t v;
      v.rst = r; v.stb = s; v.sel_n = sn; v.rd = rd; v.win = w; v.cmd = c;
      v.oe = oe; v.dout = d; v.locked = lk; v.lfsr = lf;
      return v;
   endfunction

   // window read with given command, expecting oe high
   function automatic vec_t rd_(logic [3:0] c, logic d, logic lk, logic [5:0] lf);
      return mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, c, 1'b1, d, lk, lf);
   endfunction

   function automatic vec_t idle(logic d, logic lk, logic [5:0] lf);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 1'b0, d, lk, lf);
   endfunction

   task automatic drive(logic r, logic s, logic sn, logic rd, logic [1:0] w, logic [3:0] c);
      rst       = r;
      bus_stb   = s;
      bus_sel_n = sn;
      bus_rd    = rd;
      bus_addr  = {w, 4'($urandom_range(0, 15)), c, 4'($urandom_range(0, 15))};
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step_check(string tag, logic oe, logic d, logic lk, logic [5:0] lf);
      @(posedge clk);
      #1;
      chk({tag, ".oe"},     32'(dout_oe), 32'(oe));
      chk({tag, ".dout"},   32'(dout),    32'(d));
      chk({tag, ".locked"}, 32'(locked),  32'(lk));
      chk({tag, ".lfsr"},   32'(lfsr_q),  32'(lf));
   endtask

   // behavioural model state
   int key_seq[4] = '{2, 9, 10, 9};
   bit m_unl;
   int m_prog;
   int m_lf;
   bit m_d;
   bit m_oe;

   function automatic int lf_next(int v);
      return ((v << 1) & 63) | ($countones(v & 'h30) & 1);
   endfunction

   task automatic model_apply(bit r, bit a, int c);
      if (r) begin
         m_unl = 0; m_prog = 0; m_lf = 0; m_d = 0; m_oe = 0;
         return;
      end
      m_oe = a;
      if (!a) return;
      if (m_unl) begin
         if (c == 15) begin
            m_unl = 0; m_lf = 0; m_d = 0;
         end else begin
            m_d  = $countones(m_lf & 'h21) & 1;
            m_lf = lf_next(m_lf);
         end
      end else begin
         m_d = 0;
         if (c == key_seq[m_prog]) begin
            m_prog++;
            if (m_prog == 4) begin
               m_unl = 1; m_prog = 0; m_lf = 1;
            end
         end else if (c == key_seq[0]) begin
            m_prog = 1;
         end else begin
            m_prog = 0;
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0);

      // directed table: each row is applied for one cycle, expectations are post-edge
      tbl.push_back(mk(1, 0, 0, 1, 2'b01, 4'h2, 0, 0, 1, 6'h00));
      tbl.push_back(idle(0, 1, 6'h00));
      tbl.push_back(rd_(4'h2, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 1, 6'h00));
      tbl.push_back(rd_(4'hA, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 0, 6'h01));
      tbl.push_back(rd_(4'h5, 1, 0, 6'h02));
      tbl.push_back(idle(1, 0, 6'h02));
      tbl.push_back(rd_(4'h5, 0, 0, 6'h04));
      tbl.push_back(rd_(4'h5, 0, 0, 6'h08));
      tbl.push_back(rd_(4'h5, 0, 0, 6'h10));
      tbl.push_back(rd_(4'h5, 0, 0, 6'h21));
      tbl.push_back(rd_(4'h5, 0, 0, 6'h03));
      tbl.push_back(rd_(4'h5, 1, 0, 6'h06));
      tbl.push_back(rd_(4'hF, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h5, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h5, 0, 1, 6'h00));
      // writes, out-of-window reads and deselected cycles carrying the key
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'(key_seq[k]), 0, 0, 1, 6'h00));
      end
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(0, 1, 0, 1, 2'b00, 4'(key_seq[k]), 0, 0, 1, 6'h00));
      end
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(0, 1, 1, 1, 2'b01, 4'(key_seq[k]), 0, 0, 1, 6'h00));
      end
      // wrong third nibble, then the real key
      tbl.push_back(rd_(4'h2, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h3, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h2, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 1, 6'h00));
      tbl.push_back(rd_(4'hA, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 0, 6'h01));
      tbl.push_back(rd_(4'hF, 0, 1, 6'h00));
      // repeated first nibble restarts the key
      tbl.push_back(rd_(4'h2, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h2, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 1, 6'h00));
      tbl.push_back(rd_(4'hA, 0, 1, 6'h00));
      tbl.push_back(rd_(4'h9, 0, 0, 6'h01));
      tbl.push_back(rd_(4'h5, 1, 0, 6'h02));
      tbl.push_back(rd_(4'hF, 0, 1, 6'h00));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].stb, tbl[i].sel_n, tbl[i].rd, tbl[i].win, tbl[i].cmd);
         step_check($sformatf("tbl%0d", i), tbl[i].oe, tbl[i].dout, tbl[i].locked, tbl[i].lfsr);
      end

      // reset coincident with the third key access discards progress
      drive(0, 1, 0, 1, 2'b01, 4'h2);  step_check("rk1", 1, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'h9);  step_check("rk2", 1, 0, 1, 6'h00);
      drive(1, 1, 0, 1, 2'b01, 4'hA);  step_check("rk3", 0, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'h9);  step_check("rk4", 1, 0, 1, 6'h00);
      drive(0, 0, 0, 1, 2'b01, 4'h0);  step_check("rk5", 0, 0, 1, 6'h00);

      // reset during RUN with a coincident read, then back-to-back unlock and read
      drive(0, 1, 0, 1, 2'b01, 4'h2);  step_check("rr1", 1, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'h9);  step_check("rr2", 1, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'hA);  step_check("rr3", 1, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'h9);  step_check("rr4", 1, 0, 0, 6'h01);
      drive(0, 1, 0, 1, 2'b01, 4'h5);  step_check("rr5", 1, 1, 0, 6'h02);
      drive(1, 1, 0, 1, 2'b01, 4'h5);  step_check("rr6", 0, 0, 1, 6'h00);
      drive(0, 1, 0, 1, 2'b01, 4'h5);  step_check("rr7", 1, 0, 1, 6'h00);

      // randomized traffic against the model
      drive(1, 0, 0, 1, 2'b01, 4'h0);
      model_apply(1, 0, 0);
      step_check("rnd_rst", m_oe, m_d, !m_unl, 6'(m_lf));
      for (int n = 0; n < 3000; n++) begin
         bit         r, s, sn, rdb, a;
         logic [1:0] w;
         logic [3:0] c;
         int         pick;
         r    = ($urandom_range(0, 299) == 0);
         s    = ($urandom_range(0, 99) < 80);
         sn   = ($urandom_range(0, 15) == 0);
         rdb  = ($urandom_range(0, 15) != 0);
         w    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         pick = $urandom_range(0, 19);
         if (pick < 12)       c = 4'(key_seq[pick % 4]);
         else if (pick == 12) c = 4'hF;
         else if (pick < 17)  c = 4'h5;
         else                 c = 4'($urandom_range(0, 15));
         a = s && !sn && rdb && (w == 2'b01);
         drive(r, s, sn, rdb, w, c);
         model_apply(r, a, int'(c));
         step_check($sformatf("rnd%0d", n), m_oe, m_d, !m_unl, 6'(m_lf));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
